// File: rtl/cla8_mp_sequencer.sv
// Multi-precision add/subtract sequencer: feeds one shared cla8 a byte per clock,
// LSB first, rippling the carry through a register and assembling the wide result.
`timescale 1ns/1ps
module cla8_mp_sequencer #(
  parameter int NBYTES = 4,
  localparam int W  = 8 * NBYTES,
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic [7:0]   add_a,
  output logic [7:0]   add_b,
  output logic         add_ci,
  input  logic [7:0]   add_s,
  input  logic [7:0]   add_carry
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  a_q, b_q, result_q;
  logic          c_q, cout_q, ovf_q;
  logic          last_byte;
  logic          carry_unused;

  assign last_byte    = (idx_q == IW'(NBYTES - 1));
  // Only the top two carries matter: byte carry-out and the carry into the sign bit.
  assign carry_unused = ^add_carry[5:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          // Subtraction is A + ~B + 1: invert B once here, seed the carry with 1.
          a_q      <= a;
          b_q      <= op_sub ? ~b : b;
          c_q      <= op_sub;
          idx_q    <= '0;
          result_q <= '0;
          cout_q   <= 1'b0;
          ovf_q    <= 1'b0;
          state_q  <= RUN;
        end
        RUN: begin
          result_q[8*idx_q +: 8] <= add_s;
          c_q                    <= add_carry[7];
          if (last_byte) begin
            idx_q   <= '0;
            cout_q  <= add_carry[7];
            ovf_q   <= add_carry[7] ^ add_carry[6];
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (state_q == RUN) begin
      add_a  = a_q[8*idx_q +: 8];
      add_b  = b_q[8*idx_q +: 8];
      add_ci = c_q;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_cla8_mp_sequencer.sv
// Bench for cla8_mp_sequencer: a behavioural cla8 closes the loop, and expected
// results come from wide-integer arithmetic on the operands.
`timescale 1ns/1ps
module tb_cla8_mp_sequencer;
  localparam int NBYTES = 4;
  localparam int W = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst_n, start, op_sub;
  logic [W-1:0] a, b, result;
  logic         busy, done, cout, ovf;
  logic [7:0]   add_a, add_b, add_s, add_carry;
  logic         add_ci;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  cla8_mp_sequencer #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_s(add_s), .add_carry(add_carry)
  );

  // Shared cla8: bit-serial ripple model, carry[i] is the carry out of bit i.
  always_comb begin
    logic c;
    add_s     = '0;
    add_carry = '0;
    c         = add_ci;
    for (int i = 0; i < 8; i++) begin
      add_s[i]     = add_a[i] ^ add_b[i] ^ c;
      c            = (add_a[i] & add_b[i]) | (c & (add_a[i] ^ add_b[i]));
      add_carry[i] = c;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Carry entering byte k of oa + bx + cin, from the low 8k bits of the sum.
  function automatic logic cin_at(input logic [W-1:0] oa, input logic [W-1:0] bx,
                                  input logic cin, input int k);
    logic [63:0] m, t;
    m = (64'd1 << (8 * k)) - 64'd1;
    t = (64'(oa) & m) + (64'(bx) & m) + 64'(cin);
    return t[8*k];
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".done"}, 64'(done), 64'd0);
    check({tag, ".add_a"}, 64'(add_a), 64'd0);
    check({tag, ".add_b"}, 64'(add_b), 64'd0);
    check({tag, ".add_ci"}, 64'(add_ci), 64'd0);
  endtask

  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic sub,
                       input bit inj_run, input bit inj_done);
    logic [W:0]   full;
    logic [W-1:0] bx, r;
    logic         exp_ovf;
    bx   = sub ? ~ob : ob;
    full = sub ? ({1'b0, oa} - {1'b0, ob} + (W+1)'(1) << W) : ({1'b0, oa} + {1'b0, ob});
    if (sub) full = {(oa >= ob), oa - ob};
    r = full[W-1:0];
    exp_ovf = sub ? ((oa[W-1] != ob[W-1]) && (r[W-1] != oa[W-1]))
                  : ((oa[W-1] == ob[W-1]) && (r[W-1] != oa[W-1]));

    @(negedge clk);
    a = oa; b = ob; op_sub = sub; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < NBYTES; k++) begin
      @(negedge clk);
      start = inj_run && (k == 1);
      if (start) begin
        a = $urandom; b = $urandom; op_sub = ~sub;
      end
      check($sformatf("run%0d.busy", k), 64'(busy), 64'd1);
      check($sformatf("run%0d.done", k), 64'(done), 64'd0);
      check($sformatf("run%0d.add_a", k), 64'(add_a), 64'(oa[8*k +: 8]));
      check($sformatf("run%0d.add_b", k), 64'(add_b), 64'(bx[8*k +: 8]));
      check($sformatf("run%0d.add_ci", k), 64'(add_ci),
            64'((k == 0) ? sub : cin_at(oa, bx, sub, k)));
    end
    @(negedge clk);
    start = inj_done;
    if (start) begin
      a = $urandom; b = $urandom; op_sub = ~sub;
    end
    check("done.done", 64'(done), 64'd1);
    check("done.busy", 64'(busy), 64'd1);
    check("done.result", 64'(result), 64'(r));
    check("done.cout", 64'(cout), 64'(full[W]));
    check("done.ovf", 64'(ovf), 64'(exp_ovf));
    @(negedge clk);
    start = 1'b0;
    check_idle_outputs("post1");
    check("post1.result", 64'(result), 64'(r));
    check("post1.cout", 64'(cout), 64'(full[W]));
    check("post1.ovf", 64'(ovf), 64'(exp_ovf));
    @(negedge clk);
    check("post2.busy", 64'(busy), 64'd0);
    check("post2.result", 64'(result), 64'(r));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset.result", 64'(result), 64'd0);
    check("reset.cout", 64'(cout), 64'd0);
    check("reset.ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;

    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    do_op(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    // Starts issued while busy must be dropped, not queued.
    do_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b1);
    do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b1);

    // Reset in the second RUN cycle discards the operation.
    @(negedge clk);
    a = 32'hCAFE_0001; b = 32'h1111_2222; op_sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("midrst");
    check("midrst.result", 64'(result), 64'd0);
    for (int i = 0; i < NBYTES + 2; i++) begin
      @(negedge clk);
      check($sformatf("midrst%0d.done", i), 64'(done), 64'd0);
    end
    do_op(32'hCAFE_0001, 32'h1111_2222, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom; rb = $urandom;
      if (n % 6 == 0) rb = ra;
      do_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
